// File: rtl/txfifo_rd_machine.sv
// rtl/txfifo_rd_machine.sv - TX FIFO drain: length-prefixed frames out to an AXI4-Stream master
// Pops one header word, validates the byte length, then streams ceil(L/4) payload words.
module txfifo_rd_machine #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16,
   parameter int MAX_BYTES  = 2048
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic                    txfifo_empty,
   output logic                    txfifo_rd_en,
   input  logic [DATA_WIDTH-1:0]   txfifo_dout,
   input  logic                    txfifo_valid,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic                    frame_done,
   output logic                    frame_err,
   output logic [15:0]             frame_cnt
);

   localparam int KEEP_W = DATA_WIDTH / 8;
   localparam int CNT_W  = LEN_WIDTH - 1;

   typedef enum logic [2:0] {
      IDLE, HDR_RD, HDR_WAIT, PAY_RD, PAY_WAIT, SEND, DONE, ERR
   } state_t;

   state_t                  state, state_nx;
   logic [CNT_W-1:0]        remain, remain_nx;
   logic [1:0]              len_lo, len_lo_nx;
   logic [DATA_WIDTH-1:0]   tdata_nx;
   logic [KEEP_W-1:0]       tkeep_nx, last_keep;
   logic                    tvalid_nx, tlast_nx, done_nx, err_nx;
   logic [15:0]             cnt_nx;
   logic [LEN_WIDTH-1:0]    hdr_len;
   logic [CNT_W-1:0]        hdr_words;

   assign hdr_len   = txfifo_dout[LEN_WIDTH-1:0];
   assign hdr_words = CNT_W'(hdr_len[LEN_WIDTH-1:2]) + CNT_W'(|hdr_len[1:0]);

   always_comb begin
      last_keep = '1;
      case (len_lo)
         2'd1:    last_keep = KEEP_W'(4'b0001);
         2'd2:    last_keep = KEEP_W'(4'b0011);
         2'd3:    last_keep = KEEP_W'(4'b0111);
         default: last_keep = '1;
      endcase
   end

   // rd_en is decoded from the RD states so the FIFO response lands in the single WAIT cycle.
   always_comb begin
      state_nx     = state;
      remain_nx    = remain;
      len_lo_nx    = len_lo;
      tdata_nx     = m_axis_tdata;
      tkeep_nx     = m_axis_tkeep;
      tvalid_nx    = m_axis_tvalid;
      tlast_nx     = m_axis_tlast;
      done_nx      = 1'b0;
      err_nx       = 1'b0;
      cnt_nx       = frame_cnt;
      txfifo_rd_en = 1'b0;
      case (state)
         IDLE: begin
            if (enable && !txfifo_empty) state_nx = HDR_RD;
         end
         HDR_RD: begin
            if (!txfifo_empty) begin
               txfifo_rd_en = 1'b1;
               state_nx     = HDR_WAIT;
            end
         end
         HDR_WAIT: begin
            if (txfifo_valid) begin
               if (hdr_len == '0 || hdr_len > LEN_WIDTH'(MAX_BYTES)) begin
                  err_nx   = 1'b1;
                  state_nx = ERR;
               end else begin
                  remain_nx = hdr_words;
                  len_lo_nx = hdr_len[1:0];
                  state_nx  = PAY_RD;
               end
            end
         end
         PAY_RD: begin
            if (!txfifo_empty) begin
               txfifo_rd_en = 1'b1;
               state_nx     = PAY_WAIT;
            end
         end
         PAY_WAIT: begin
            if (txfifo_valid) begin
               tdata_nx  = txfifo_dout;
               tvalid_nx = 1'b1;
               tlast_nx  = (remain == CNT_W'(1));
               tkeep_nx  = (remain == CNT_W'(1)) ? last_keep : '1;
               remain_nx = remain - CNT_W'(1);
               state_nx  = SEND;
            end
         end
         SEND: begin
            if (m_axis_tready) begin
               tvalid_nx = 1'b0;
               tlast_nx  = 1'b0;
               if (m_axis_tlast) begin
                  done_nx  = 1'b1;
                  cnt_nx   = frame_cnt + 16'd1;
                  state_nx = DONE;
               end else begin
                  state_nx = PAY_RD;
               end
            end
         end
         DONE:    state_nx = IDLE;
         ERR:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= IDLE;
         remain        <= '0;
         len_lo        <= '0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         frame_done    <= 1'b0;
         frame_err     <= 1'b0;
         frame_cnt     <= '0;
      end else begin
         state         <= state_nx;
         remain        <= remain_nx;
         len_lo        <= len_lo_nx;
         m_axis_tdata  <= tdata_nx;
         m_axis_tkeep  <= tkeep_nx;
         m_axis_tvalid <= tvalid_nx;
         m_axis_tlast  <= tlast_nx;
         frame_done    <= done_nx;
         frame_err     <= err_nx;
         frame_cnt     <= cnt_nx;
      end
   end

endmodule

// File: tb/tb_txfifo_rd_machine.sv
// tb/tb_txfifo_rd_machine.sv - directed bench for txfifo_rd_machine
// A small FIFO model feeds frames; a monitor tallies reads, beats and pulses.
module tb_txfifo_rd_machine;

   logic        clk = 1'b0;
   logic        reset_n, enable, txfifo_empty, txfifo_rd_en, txfifo_valid;
   logic [31:0] txfifo_dout, m_axis_tdata;
   logic [3:0]  m_axis_tkeep;
   logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, frame_done, frame_err;
   logic [15:0] frame_cnt;

   int checks = 0;
   int failures = 0;

   logic [31:0] mem [0:255];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int rd_total = 0, beat_total = 0, done_total = 0, err_total = 0, both_total = 0;
   logic [31:0] bd [0:255];
   logic [3:0]  bk [0:255];
   logic        bl [0:255];
   int exp_cnt = 0;

   always #5 clk = ~clk;

   txfifo_rd_machine #(.DATA_WIDTH(32), .LEN_WIDTH(16), .MAX_BYTES(2048)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .txfifo_empty(txfifo_empty),
      .txfifo_rd_en(txfifo_rd_en), .txfifo_dout(txfifo_dout), .txfifo_valid(txfifo_valid),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .frame_done(frame_done),
      .frame_err(frame_err), .frame_cnt(frame_cnt)
   );

   assign txfifo_empty = (rd_ptr == wr_ptr);

   initial txfifo_valid = 1'b0;
   initial txfifo_dout  = 32'h0;

   always @(posedge clk) begin
      if (txfifo_rd_en) begin
         txfifo_dout  <= mem[rd_ptr[7:0]];
         rd_ptr       <= rd_ptr + 1;
         txfifo_valid <= 1'b1;
      end else begin
         txfifo_dout  <= 32'hDEAD_BEEF;
         txfifo_valid <= 1'b0;
      end
   end

   always @(posedge clk) begin
      if (txfifo_rd_en) rd_total <= rd_total + 1;
      if (m_axis_tvalid && m_axis_tready) begin
         bd[beat_total[7:0]] <= m_axis_tdata;
         bk[beat_total[7:0]] <= m_axis_tkeep;
         bl[beat_total[7:0]] <= m_axis_tlast;
         beat_total <= beat_total + 1;
      end
      if (frame_done) done_total <= done_total + 1;
      if (frame_err) err_total <= err_total + 1;
      if (frame_done && frame_err) both_total <= both_total + 1;
   end

   task automatic push(input logic [31:0] w);
      mem[wr_ptr[7:0]] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic wait_evt(input int budget, output bit ok);
      int base;
      base = done_total + err_total;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_total + err_total > base) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_tvalid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (m_axis_tvalid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      checks++;
      if ({m_axis_tvalid, m_axis_tlast, frame_done, frame_err} !== 4'b0) begin
         failures++; $display("FAIL reset_flags got=%b want=0000", {m_axis_tvalid, m_axis_tlast, frame_done, frame_err});
      end
      checks++;
      if (m_axis_tdata !== 32'h0 || m_axis_tkeep !== 4'h0) begin
         failures++; $display("FAIL reset_data got=%h/%h want=0/0", m_axis_tdata, m_axis_tkeep);
      end
      checks++;
      if (frame_cnt !== 16'h0) begin
         failures++; $display("FAIL reset_cnt got=%h want=0", frame_cnt);
      end
      reset_n = 1'b1;
      enable  = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (txfifo_rd_en !== 1'b0 || m_axis_tvalid !== 1'b0) begin
         failures++; $display("FAIL idle_quiet got rd=%b tvalid=%b want 0 0", txfifo_rd_en, m_axis_tvalid);
      end
   endtask

   task automatic test_basic;
      int b0, r0, d0;
      bit ok;
      b0 = beat_total; r0 = rd_total; d0 = done_total;
      m_axis_tready = 1'b1;
      push(32'h0000_0008); push(32'h1111_1111); push(32'h2222_2222);
      wait_evt(60, ok);
      exp_cnt++;
      checks++;
      if (!ok || beat_total - b0 != 2) begin
         failures++; $display("FAIL basic_beats got=%0d ok=%0d want=2", beat_total - b0, ok);
      end
      checks++;
      if (bd[b0] !== 32'h1111_1111 || bk[b0] !== 4'hF || bl[b0] !== 1'b0) begin
         failures++; $display("FAIL basic_beat0 got=%h/%h/%b want=11111111/f/0", bd[b0], bk[b0], bl[b0]);
      end
      checks++;
      if (bd[b0+1] !== 32'h2222_2222 || bk[b0+1] !== 4'hF || bl[b0+1] !== 1'b1) begin
         failures++; $display("FAIL basic_beat1 got=%h/%h/%b want=22222222/f/1", bd[b0+1], bk[b0+1], bl[b0+1]);
      end
      checks++;
      if (done_total - d0 != 1 || frame_cnt !== 16'(exp_cnt)) begin
         failures++; $display("FAIL basic_done got=%0d cnt=%0d want=1 cnt=%0d", done_total - d0, frame_cnt, exp_cnt);
      end
      checks++;
      if (rd_total - r0 != 3) begin
         failures++; $display("FAIL basic_reads got=%0d want=3", rd_total - r0);
      end
   endtask

   task automatic test_keep;
      logic [15:0] lens [3];
      logic [3:0]  keeps [3];
      int b0;
      bit ok;
      lens  = '{16'd5, 16'd6, 16'd7};
      keeps = '{4'b0001, 4'b0011, 4'b0111};
      m_axis_tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         b0 = beat_total;
         push({16'hABCD, lens[i]}); push(32'hA000_0000 + i); push(32'hB000_0000 + i);
         wait_evt(60, ok);
         exp_cnt++;
         checks++;
         if (!ok || beat_total - b0 != 2) begin
            failures++; $display("FAIL keep_beats L=%0d got=%0d want=2", lens[i], beat_total - b0);
         end
         checks++;
         if (bk[b0] !== 4'hF || bl[b0] !== 1'b0) begin
            failures++; $display("FAIL keep_first L=%0d got=%h/%b want=f/0", lens[i], bk[b0], bl[b0]);
         end
         checks++;
         if (bk[b0+1] !== keeps[i] || bl[b0+1] !== 1'b1 || bd[b0+1] !== 32'hB000_0000 + i) begin
            failures++; $display("FAIL keep_last L=%0d got=%h/%b/%h want=%h/1/%h", lens[i], bk[b0+1], bl[b0+1], bd[b0+1], keeps[i], 32'hB000_0000 + i);
         end
      end
      checks++;
      if (frame_cnt !== 16'(exp_cnt)) begin
         failures++; $display("FAIL keep_cnt got=%0d want=%0d", frame_cnt, exp_cnt);
      end
   endtask

   task automatic test_err;
      logic [31:0] hdrs [4];
      int b0, r0, e0, d0;
      bit ok, all_ok;
      hdrs = '{32'h0000_0000, 32'h0000_0FA0, 32'h0000_0801, 32'h0001_0000};
      b0 = beat_total; r0 = rd_total; e0 = err_total; d0 = done_total;
      all_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push(hdrs[i]);
         wait_evt(20, ok);
         if (!ok) all_ok = 1'b0;
         repeat (2) @(negedge clk);
      end
      checks++;
      if (!all_ok || err_total - e0 != 4) begin
         failures++; $display("FAIL err_pulses got=%0d want=4", err_total - e0);
      end
      checks++;
      if (beat_total - b0 != 0 || done_total - d0 != 0) begin
         failures++; $display("FAIL err_no_beats got beats=%0d done=%0d want 0 0", beat_total - b0, done_total - d0);
      end
      checks++;
      if (rd_total - r0 != 4) begin
         failures++; $display("FAIL err_reads got=%0d want=4", rd_total - r0);
      end
      checks++;
      if (frame_cnt !== 16'(exp_cnt)) begin
         failures++; $display("FAIL err_cnt got=%0d want=%0d", frame_cnt, exp_cnt);
      end
   endtask

   task automatic test_stall;
      int b0, rb;
      bit ok, stable;
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
      b0 = beat_total;
      m_axis_tready = 1'b0;
      push(32'h0000_000C); push(32'hC000_0001); push(32'hC000_0002); push(32'hC000_0003);
      wait_tvalid(30, ok);
      m_axis_tready = 1'b1;
      @(negedge clk);
      m_axis_tready = 1'b0;
      wait_tvalid(30, ok);
      d = m_axis_tdata; k = m_axis_tkeep; l = m_axis_tlast; rb = rd_total;
      stable = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (!m_axis_tvalid || m_axis_tdata !== d || m_axis_tkeep !== k || m_axis_tlast !== l || txfifo_rd_en)
            stable = 1'b0;
      end
      checks++;
      if (!ok || d !== 32'hC000_0002 || k !== 4'hF || l !== 1'b0) begin
         failures++; $display("FAIL stall_beat2 got=%h/%h/%b want=c0000002/f/0", d, k, l);
      end
      checks++;
      if (!stable) begin
         failures++; $display("FAIL stall_stable got=0 want=1");
      end
      checks++;
      if (rd_total != rb) begin
         failures++; $display("FAIL stall_no_read got=%0d want=0", rd_total - rb);
      end
      m_axis_tready = 1'b1;
      wait_evt(40, ok);
      exp_cnt++;
      checks++;
      if (!ok || beat_total - b0 != 3 || bd[b0+2] !== 32'hC000_0003 || bl[b0+2] !== 1'b1 || bk[b0+2] !== 4'hF) begin
         failures++; $display("FAIL stall_tail got beats=%0d last=%h/%b/%h want 3 c0000003/1/f", beat_total - b0, bd[b0+2], bl[b0+2], bk[b0+2]);
      end
   endtask

   task automatic test_empty_reset;
      int b0, r0, d0;
      bit ok;
      b0 = beat_total; r0 = rd_total; d0 = done_total;
      m_axis_tready = 1'b0;
      push(32'h0000_0008);
      repeat (12) @(negedge clk);
      checks++;
      if (rd_total - r0 != 1 || beat_total != b0 || m_axis_tvalid !== 1'b0) begin
         failures++; $display("FAIL empty_stall got reads=%0d tvalid=%b want 1 0", rd_total - r0, m_axis_tvalid);
      end
      push(32'hE000_0001); push(32'hE000_0002);
      wait_tvalid(20, ok);
      checks++;
      if (!ok || m_axis_tdata !== 32'hE000_0001) begin
         failures++; $display("FAIL empty_resume got=%h want=e0000001", m_axis_tdata);
      end
      m_axis_tready = 1'b1;
      @(negedge clk);
      m_axis_tready = 1'b0;
      wait_tvalid(20, ok);
      reset_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({m_axis_tvalid, m_axis_tlast, frame_done, frame_err, txfifo_rd_en} !== 5'b0 ||
          m_axis_tdata !== 32'h0 || m_axis_tkeep !== 4'h0 || frame_cnt !== 16'h0) begin
         failures++; $display("FAIL midreset got v=%b l=%b d=%h k=%h cnt=%h want all 0", m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, frame_cnt);
      end
      reset_n = 1'b1;
      exp_cnt = 0;
      m_axis_tready = 1'b1;
      push(32'h0000_0004); push(32'hF000_000F);
      wait_evt(40, ok);
      exp_cnt++;
      checks++;
      if (!ok || done_total - d0 != 1 || frame_cnt !== 16'(exp_cnt) || bd[beat_total-1] !== 32'hF000_000F) begin
         failures++; $display("FAIL after_reset got done=%0d cnt=%0d data=%h want 1 %0d f000000f", done_total - d0, frame_cnt, bd[beat_total-1], exp_cnt);
      end
   endtask

   task automatic test_wrap;
      bit ok;
      @(negedge clk);
      force dut.frame_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.frame_cnt;
      @(negedge clk);
      checks++;
      if (frame_cnt !== 16'hFFFF) begin
         failures++; $display("FAIL wrap_preload got=%h want=ffff", frame_cnt);
      end
      m_axis_tready = 1'b1;
      push(32'h0000_0003); push(32'h0012_3456);
      wait_evt(40, ok);
      checks++;
      if (!ok || frame_cnt !== 16'h0000) begin
         failures++; $display("FAIL wrap_cnt got=%h want=0000", frame_cnt);
      end
      checks++;
      if (bk[beat_total-1] !== 4'b0111 || bl[beat_total-1] !== 1'b1) begin
         failures++; $display("FAIL wrap_keep got=%h/%b want=7/1", bk[beat_total-1], bl[beat_total-1]);
      end
      checks++;
      if (both_total != 0) begin
         failures++; $display("FAIL done_err_overlap got=%0d want=0", both_total);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      enable = 1'b0;
      m_axis_tready = 1'b0;
      repeat (3) @(negedge clk);
      test_reset;
      test_basic;
      test_keep;
      test_err;
      test_stall;
      test_empty_reset;
      test_wrap;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
